// File: rtl/uart_rx_fifo_if.sv
// Bundle of the buart-facing ingest handshake and the CPU-facing pop/status port.
// master drives the byte source and pop/flush strobes; slave is the buffer itself.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  uart_valid;
    logic [DATA_WIDTH-1:0] uart_data;
    logic                  uart_rd;
    logic                  cpu_rd;
    logic                  cpu_clr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;

    modport master (
        output uart_valid, uart_data, cpu_rd, cpu_clr,
        input  uart_rd, rdata, empty, full, count, overflow
    );

    modport slave (
        input  uart_valid, uart_data, cpu_rd, cpu_clr,
        output uart_rd, rdata, empty, full, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: ingests buart bytes via a 3-cycle IDLE/ACK/SETTLE handshake, pops into a registered rdata.
// Pop data appears the cycle after cpu_rd; bytes arriving while full are acknowledged, dropped and flagged in overflow.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           resetq,
    uart_rx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LP_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_SETTLE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_take;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LP_FULL);
    // Flush wins over everything, so it masks both pop and ingest.
    assign w_pop   = bus.cpu_rd && !w_empty && !bus.cpu_clr;
    assign w_take  = (r_state == ST_IDLE) && bus.uart_valid && !bus.cpu_clr;
    assign w_push  = w_take && (!w_full || w_pop);
    assign w_drop  = w_take && w_full && !w_pop;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.cpu_clr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (bus.uart_valid) w_state_nxt = ST_ACK;
                ST_ACK:    w_state_nxt = ST_SETTLE;
                ST_SETTLE: w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Storage has no reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.uart_data;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_rdata    <= '0;
        end else if (bus.cpu_clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (bus.cpu_rd) begin
                if (w_pop) begin
                    r_rdata <= r_mem[r_rptr];
                    r_rptr  <= r_rptr + 1'b1;
                end else begin
                    r_rdata <= '0;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.uart_rd  = (r_state == ST_ACK);
    assign bus.rdata    = r_rdata;
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
endmodule
